// File: rtl/e203_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e203_clkgate_ctrl
// Description : Activity-based enable controller for one e203_clkgate cell.
//               Runs on the free-running clock, watches the unit's busy and
//               request lines, stops the unit clock after a programmable idle
//               hysteresis and restores it (with a settle period) on demand.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: E203_CLKGATE_CTRL_STAT_EN
//   When defined, a saturating STAT_W-bit gated-cycle counter is added along
//   with the stat_clr / stat_gated_cyc ports. FSM behaviour is identical
//   whether or not the macro is defined.
// ----------------------------------------------------------------------------
// Parameters:
//   IDLE_CYC : consecutive idle cycles spent in IDLE before gating (1..2^CNT_W-1)
//   WAKE_CYC : cycles the clock runs after ungating before ready (1..2^CNT_W-1)
//   CNT_W    : width of the shared down-counter
//   STAT_W   : width of the gated-cycle statistics counter
// Ports:
//   clk            in   free-running clock
//   rst            in   asynchronous active-high reset
//   unit_active    in   gated unit reports in-flight work
//   req_valid      in   a requester wants the unit
//   force_on       in   test/debug override: blocks gating, forces wake
//   clock_en       out  to e203_clkgate clock_en (1 = clock runs)
//   req_ready      out  unit clocked and settled; requester may hand off
//   gated          out  unit clock currently stopped
//   stat_clr       in   clear statistics counter        (macro only)
//   stat_gated_cyc out  saturating gated-cycle count     (macro only)
// ============================================================================
module e203_clkgate_ctrl #(
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 4,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              unit_active,
  input  logic              req_valid,
  input  logic              force_on,
  output logic              clock_en,
  output logic              req_ready,
  output logic              gated
`ifdef E203_CLKGATE_CTRL_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_gated_cyc
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  // Counter reload values; the countdown includes the terminal zero cycle,
  // so loading N-1 yields exactly N cycles in the counting state.
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wake;

  assign wake = unit_active | req_valid | force_on;

  // --------------------------------------------------------------------------
  // Control FSM. Outputs are registered alongside the state so clock_en has
  // no combinational path from any input and cannot glitch. Each transition
  // loads the output values that belong to the destination state. The async
  // reset restores the clock immediately, without needing a clock edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      clock_en  <= 1'b1;
      req_ready <= 1'b1;
      gated     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!wake) begin
            state <= IDLE;
            cnt   <= IDLE_LOAD;
          end
          clock_en  <= 1'b1;
          req_ready <= 1'b1;
          gated     <= 1'b0;
        end

        IDLE: begin
          if (wake) begin
            // Activity aborts the countdown; it wins over cnt==0.
            state     <= RUN;
            clock_en  <= 1'b1;
            req_ready <= 1'b1;
            gated     <= 1'b0;
          end else if (cnt == '0) begin
            state     <= GATED;
            clock_en  <= 1'b0;
            req_ready <= 1'b0;
            gated     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GATED: begin
          if (wake) begin
            // Clock restarts right away; ready waits for the settle period.
            state     <= WAKE;
            cnt       <= WAKE_LOAD;
            clock_en  <= 1'b1;
            req_ready <= 1'b0;
            gated     <= 1'b0;
          end
        end

        WAKE: begin
          // Inputs are ignored: a wake-up always completes once started.
          if (cnt == '0) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
          clock_en <= 1'b1;
          gated    <= 1'b0;
        end

        default: begin
          state     <= RUN;
          cnt       <= '0;
          clock_en  <= 1'b1;
          req_ready <= 1'b1;
          gated     <= 1'b0;
        end
      endcase
    end
  end

`ifdef E203_CLKGATE_CTRL_STAT_EN
  // --------------------------------------------------------------------------
  // Gated-cycle statistics: counts every cycle spent in GATED, saturating at
  // all-ones so a long sleep never wraps to a misleadingly small value. The
  // clear request has priority over the increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_gated_cyc <= '0;
    end else if (stat_clr) begin
      stat_gated_cyc <= '0;
    end else if ((state == GATED) && (stat_gated_cyc != {STAT_W{1'b1}})) begin
      stat_gated_cyc <= stat_gated_cyc + 1'b1;
    end
  end
`else
  // STAT_W only sizes the optional counter; keep it referenced.
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

endmodule
`default_nettype wire
